// File: rtl/mc_pkg.sv
// Shared definitions for the multicycle MIPS microsequencer and its control store:
// micro-state map, addrctl sequencing codes and the opcodes the dispatch tables decode.
package mc_pkg;

   localparam int MC_STATE_W = 4;

   typedef enum logic [3:0] {
      FETCH   = 4'd0,
      DECODE  = 4'd1,
      MEMADR  = 4'd2,
      MEMRD   = 4'd3,
      MEMWB   = 4'd4,
      MEMWR   = 4'd5,
      RTYPEEX = 4'd6,
      RTYPEWB = 4'd7,
      BEQEX   = 4'd8,
      JEX     = 4'd9,
      HALT    = 4'd10
   } mc_state_e;

   typedef enum logic [1:0] {
      AC_FETCH = 2'b00,
      AC_DISP1 = 2'b01,
      AC_DISP2 = 2'b10,
      AC_SEQ   = 2'b11
   } mc_addrctl_e;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_J     = 6'b000010;

   // Codes above HALT have no microcode behind them.
   function automatic logic is_valid_state(input logic [3:0] s);
      return (s <= HALT);
   endfunction

   // States that wait on the memory handshake before moving on.
   function automatic logic is_wait_state(input logic [3:0] s);
      return (s == FETCH) || (s == MEMRD) || (s == MEMWR);
   endfunction

   // Execution states whose return to FETCH retires an instruction.
   function automatic logic is_retire_state(input logic [3:0] s);
      return (s >= MEMADR) && (s <= JEX);
   endfunction

endpackage

// File: rtl/dispatch_rom.sv
// Opcode dispatch tables: sel=0 selects the DECODE table, sel=1 the MEMADR table.
// Opcodes absent from the selected table raise illegal; next_state then defaults to FETCH.
module dispatch_rom
   import mc_pkg::*;
(
   input  logic [5:0] opcode,
   input  logic       sel,
   output logic [3:0] next_state,
   output logic       illegal
);

   // Table lookup; every miss is reported rather than silently mapped.
   always_comb begin
      next_state = FETCH;
      illegal    = 1'b0;
      if (sel == 1'b0) begin
         case (opcode)
            OP_RTYPE:     next_state = RTYPEEX;
            OP_LW, OP_SW: next_state = MEMADR;
            OP_BEQ:       next_state = BEQEX;
            OP_J:         next_state = JEX;
            default:      illegal    = 1'b1;
         endcase
      end else begin
         case (opcode)
            OP_LW:   next_state = MEMRD;
            OP_SW:   next_state = MEMWR;
            default: illegal    = 1'b1;
         endcase
      end
   end

endmodule

// File: rtl/mc_checker.sv
// Run-time invariants of the microsequencer outputs; carries no functional logic.
module mc_checker
   import mc_pkg::*;
#(
   parameter int STATE_W = 4
)
(
   input logic               clock,
   input logic               reset,
   input logic [STATE_W-1:0] state,
   input logic               halted
);

   logic armed_r;

   // Stays quiet until a reset has been seen so power-up contents are not flagged.
   always_ff @(posedge clock) begin
      if (reset) begin
         armed_r <= 1'b1;
      end else begin
         armed_r <= armed_r;
      end
   end

   halted_tracks_state: assert property (@(posedge clock) disable iff (reset || !armed_r)
      halted == (state == HALT));

   state_in_map: assert property (@(posedge clock) disable iff (reset || !armed_r)
      is_valid_state(state));

endmodule

// File: rtl/microsequencer.sv
// Micro-state register and next-state logic feeding the microprogram control store;
// also flags illegal opcodes at dispatch and counts retired instructions.
module microsequencer
   import mc_pkg::*;
#(
   parameter int STATE_W      = 4,
   parameter int COUNT_W      = 16,
   parameter bit ILLEGAL_HALT = 1'b1
)
(
   input  logic               clock,
   input  logic               reset,
   input  logic [5:0]         opcode,
   input  logic [1:0]         addrctl,
   input  logic               mem_ready,
   output logic [STATE_W-1:0] state,
   output logic               illegal,
   output logic               halted,
   output logic [COUNT_W-1:0] instr_count
);

   logic [STATE_W-1:0] state_r;
   logic [STATE_W-1:0] state_nx_s;
   logic               illegal_r;
   logic               halted_r;
   logic [COUNT_W-1:0] count_r;
   logic               advance_s;
   logic               illegal_set_s;
   logic               count_inc_s;
   logic               halted_nx_s;
   logic [3:0]         disp_next_s;
   logic               disp_illegal_s;

   dispatch_rom u_dispatch_rom (
      .opcode     (opcode),
      .sel        (addrctl == AC_DISP2),
      .next_state (disp_next_s),
      .illegal    (disp_illegal_s)
   );

   // State and status registers; reset wins over HALT and stalls alike.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_r   <= FETCH;
         illegal_r <= 1'b0;
         halted_r  <= 1'b0;
         count_r   <= '0;
      end else begin
         state_r   <= state_nx_s;
         illegal_r <= illegal_r | illegal_set_s;
         halted_r  <= halted_nx_s;
         if (count_inc_s) begin
            count_r <= count_r + COUNT_W'(1);
         end else begin
            count_r <= count_r;
         end
      end
   end

   // Next micro-state: HALT hold, invalid-code recovery, memory stall, then addrctl.
   always_comb begin
      state_nx_s    = state_r;
      advance_s     = 1'b0;
      illegal_set_s = 1'b0;
      if (state_r == HALT) begin
         state_nx_s = state_r;
      end else if (!is_valid_state(state_r)) begin
         state_nx_s = FETCH;
      end else if (is_wait_state(state_r) && !mem_ready) begin
         state_nx_s = state_r;
      end else begin
         advance_s = 1'b1;
         case (addrctl)
            AC_FETCH: state_nx_s = FETCH;
            AC_DISP1, AC_DISP2: begin
               if (disp_illegal_s) begin
                  illegal_set_s = 1'b1;
                  state_nx_s    = ILLEGAL_HALT ? HALT : FETCH;
               end else begin
                  state_nx_s = disp_next_s;
               end
            end
            AC_SEQ:   state_nx_s = state_r + STATE_W'(1);
            default:  state_nx_s = FETCH;
         endcase
      end
   end

   // Retire accounting and the HALT indicator that accompanies the next state.
   always_comb begin
      count_inc_s = 1'b0;
      halted_nx_s = 1'b0;
      if (advance_s && (addrctl == AC_FETCH) && is_retire_state(state_r)) begin
         count_inc_s = 1'b1;
      end else begin
         count_inc_s = 1'b0;
      end
      if (state_nx_s == HALT) begin
         halted_nx_s = 1'b1;
      end else begin
         halted_nx_s = 1'b0;
      end
   end

   mc_checker #(.STATE_W(STATE_W)) u_mc_checker (
      .clock  (clock),
      .reset  (reset),
      .state  (state_r),
      .halted (halted_r)
   );

   assign state       = state_r;
   assign illegal     = illegal_r;
   assign halted      = halted_r;
   assign instr_count = count_r;

endmodule

// File: tb/tb_microsequencer.sv
// Randomized and directed checks of three microsequencer configurations against a
// table-driven behavioural model of the micro-state machine.
module tb_microsequencer;

   localparam logic [5:0] RT  = 6'b000000;
   localparam logic [5:0] LW  = 6'b100011;
   localparam logic [5:0] SW  = 6'b101011;
   localparam logic [5:0] BEQ = 6'b000100;
   localparam logic [5:0] JMP = 6'b000010;
   localparam logic [5:0] BAD = 6'b111111;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic [5:0] opcode = 6'd0;
   logic [1:0] addrctl = 2'd0;
   logic       mem_ready = 1'b1;

   logic [3:0]  st0, st1, st2;
   logic        ill0, ill1, ill2;
   logic        hl0, hl1, hl2;
   logic [15:0] cnt0, cnt1;
   logic [3:0]  cnt2;

   microsequencer dut0 (.clock(clock), .reset(reset), .opcode(opcode), .addrctl(addrctl),
      .mem_ready(mem_ready), .state(st0), .illegal(ill0), .halted(hl0), .instr_count(cnt0));
   microsequencer #(.ILLEGAL_HALT(1'b0)) dut1 (.clock(clock), .reset(reset), .opcode(opcode),
      .addrctl(addrctl), .mem_ready(mem_ready), .state(st1), .illegal(ill1), .halted(hl1),
      .instr_count(cnt1));
   microsequencer #(.COUNT_W(4)) dut2 (.clock(clock), .reset(reset), .opcode(opcode),
      .addrctl(addrctl), .mem_ready(mem_ready), .state(st2), .illegal(ill2), .halted(hl2),
      .instr_count(cnt2));

   always #5 clock = ~clock;

   int n_checks = 0;
   int n_fail   = 0;

   int mst[3];
   bit mill[3];
   int mcnt[3];
   int halt_on_ill[3] = '{1, 0, 1};
   int cw[3]          = '{16, 16, 4};
   int d1[int];
   int d2[int];

   int lw_exp[5]     = '{1, 2, 3, 4, 0};
   logic [5:0] mix_op[14] = '{SW, SW, SW, SW, RT, RT, RT, RT, BEQ, BEQ, BEQ, JMP, JMP, JMP};
   int mix_exp[14]   = '{1, 2, 5, 0, 1, 6, 7, 0, 1, 8, 0, 1, 9, 0};
   bit stall_rdy[10] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
   int stall_exp[10] = '{0, 0, 0, 1, 2, 3, 3, 3, 4, 0};

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   // addrctl the shipped microprogram stores for each micro-state
   function automatic logic [1:0] prog_ac(input int s);
      case (s)
         0, 3, 6: return 2'b11;
         1:       return 2'b01;
         2:       return 2'b10;
         default: return 2'b00;
      endcase
   endfunction

   task automatic model_step(input bit rst, input logic [5:0] op, input logic [1:0] ac,
                             input bit rdy);
      for (int i = 0; i < 3; i++) begin
         if (rst) begin
            mst[i] = 0; mill[i] = 1'b0; mcnt[i] = 0;
         end else if (mst[i] == 10) begin
            mst[i] = 10;
         end else if ((mst[i] == 0 || mst[i] == 3 || mst[i] == 5) && !rdy) begin
            mst[i] = mst[i];
         end else if (ac == 2'b00) begin
            if (mst[i] >= 2 && mst[i] <= 9) mcnt[i] = (mcnt[i] + 1) % (1 << cw[i]);
            mst[i] = 0;
         end else if (ac == 2'b11) begin
            mst[i] = (mst[i] + 1) % 16;
         end else if (ac == 2'b01 && d1.exists(int'(op))) begin
            mst[i] = d1[int'(op)];
         end else if (ac == 2'b10 && d2.exists(int'(op))) begin
            mst[i] = d2[int'(op)];
         end else begin
            mill[i] = 1'b1;
            mst[i]  = (halt_on_ill[i] != 0) ? 10 : 0;
         end
      end
   endtask

   task automatic check_inst(input int i, input logic [3:0] s, input logic il, input logic hl,
                             input logic [31:0] c);
      check_eq($sformatf("state%0d", i), {28'd0, s}, mst[i]);
      check_eq($sformatf("illegal%0d", i), {31'd0, il}, {31'd0, mill[i]});
      check_eq($sformatf("halted%0d", i), {31'd0, hl}, (mst[i] == 10) ? 32'd1 : 32'd0);
      check_eq($sformatf("count%0d", i), c, mcnt[i]);
   endtask

   task automatic cyc(input bit rst, input logic [5:0] op, input logic [1:0] ac, input bit rdy);
      reset = rst; opcode = op; addrctl = ac; mem_ready = rdy;
      @(posedge clock);
      model_step(rst, op, ac, rdy);
      @(negedge clock);
      check_inst(0, st0, ill0, hl0, {16'd0, cnt0});
      check_inst(1, st1, ill1, hl1, {16'd0, cnt1});
      check_inst(2, st2, ill2, hl2, {28'd0, cnt2});
   endtask

   task automatic run_prog(input int mi, input logic [5:0] op, input bit rdy);
      cyc(1'b0, op, prog_ac(mst[mi]), rdy);
   endtask

   task automatic do_reset();
      cyc(1'b1, 6'($urandom), 2'($urandom), 1'($urandom));
   endtask

   initial begin
      logic [5:0] cur_op;
      d1[int'(RT)] = 6; d1[int'(LW)] = 2; d1[int'(SW)] = 2; d1[int'(BEQ)] = 8; d1[int'(JMP)] = 9;
      d2[int'(LW)] = 3; d2[int'(SW)] = 5;
      @(negedge clock);
      do_reset();
      do_reset();
      check_eq("reset_state", {28'd0, st0}, 32'd0);
      check_eq("reset_halted", {31'd0, hl0}, 32'd0);

      foreach (lw_exp[k]) begin
         run_prog(0, LW, 1'b1);
         check_eq("lw_seq", {28'd0, st0}, lw_exp[k]);
      end
      check_eq("lw_count", {16'd0, cnt0}, 32'd1);

      do_reset();
      foreach (mix_exp[k]) begin
         run_prog(0, mix_op[k], 1'b1);
         check_eq("mix_seq", {28'd0, st0}, mix_exp[k]);
      end
      check_eq("mix_count", {16'd0, cnt0}, 32'd4);
      check_eq("mix_illegal", {31'd0, ill0}, 32'd0);

      do_reset();
      foreach (stall_exp[k]) begin
         run_prog(0, LW, stall_rdy[k]);
         check_eq("stall_seq", {28'd0, st0}, stall_exp[k]);
      end
      check_eq("stall_count", {16'd0, cnt0}, 32'd1);

      do_reset();
      run_prog(0, BAD, 1'b1);
      run_prog(0, BAD, 1'b1);
      check_eq("ill_halt_state", {28'd0, st0}, 32'd10);
      check_eq("ill_halt_flag", {31'd0, hl0}, 32'd1);
      check_eq("ill_flag", {31'd0, ill0}, 32'd1);
      check_eq("ill_nohalt_state", {28'd0, st1}, 32'd0);
      check_eq("ill_nohalt_flag", {31'd0, ill1}, 32'd1);
      check_eq("ill_nohalt_count", {16'd0, cnt1}, 32'd0);
      for (int k = 0; k < 5; k++) run_prog(1, LW, 1'b1);
      check_eq("after_ill_lw_count", {16'd0, cnt1}, 32'd1);
      check_eq("after_ill_lw_sticky", {31'd0, ill1}, 32'd1);
      for (int k = 0; k < 20; k++) begin
         cyc(1'b0, 6'($urandom), 2'($urandom), 1'($urandom));
         check_eq("halt_hold", {28'd0, st0}, 32'd10);
      end
      do_reset();
      check_eq("halt_reset_state", {28'd0, st0}, 32'd0);
      check_eq("halt_reset_illegal", {31'd0, ill0}, 32'd0);
      check_eq("halt_reset_halted", {31'd0, hl0}, 32'd0);

      do_reset();
      for (int k = 0; k < 48; k++) run_prog(2, JMP, 1'b1);
      check_eq("wrap_count4", {28'd0, cnt2}, 32'd0);
      check_eq("wrap_count16", {16'd0, cnt0}, 32'd16);
      for (int k = 0; k < 3; k++) run_prog(2, LW, 1'b1);
      check_eq("pre_reset_state", {28'd0, st2}, 32'd3);
      do_reset();
      check_eq("mid_reset_state", {28'd0, st2}, 32'd0);
      check_eq("mid_reset_count", {28'd0, cnt2}, 32'd0);

      cur_op = LW;
      for (int n = 0; n < 3000; n++) begin
         bit r;
         logic [1:0] ac;
         if (mst[0] == 0) begin
            case ($urandom_range(0, 5))
               0:       cur_op = RT;
               1:       cur_op = LW;
               2:       cur_op = SW;
               3:       cur_op = BEQ;
               4:       cur_op = JMP;
               default: cur_op = 6'($urandom);
            endcase
         end
         ac = ($urandom_range(0, 19) == 0) ? 2'($urandom) : prog_ac(mst[0]);
         r  = ($urandom_range(0, 99) == 0) || (mst[0] == 10 && $urandom_range(0, 9) == 0);
         cyc(r, cur_op, ac, $urandom_range(0, 3) != 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
